// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_e;

   localparam int PIPE_CNT_W = 2;

   // Fill bit for the default NOP payload; BUBBLE defaults to all copies of it.
   localparam logic PIPE_NOP_BIT = 1'b0;

   function automatic logic [PIPE_CNT_W-1:0] state_count(input pipe_state_e s);
      logic [PIPE_CNT_W-1:0] c;
      case (s)
         PS_ONE:  c = 2'd1;
         PS_TWO:  c = 2'd2;
         default: c = 2'd0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: load-enabled register that clears to the bubble value.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int                WIDTH  = 32,
   parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{PIPE_NOP_BIT}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset and clear both return the slot to the bubble; otherwise load when asked.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         q <= BUBBLE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer that makes in_ready a pure flop output.
//
// state    | meaning
// ---------+----------------------------------------------
// PS_EMPTY | no entry held, out_data shows BUBBLE
// PS_ONE   | head entry in main slot
// PS_TWO   | head in main, next entry in skid (SKID=1 only)
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter int               SKID   = 1,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{PIPE_NOP_BIT}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [PIPE_CNT_W-1:0] count
);

   pipe_state_e      state;
   pipe_state_e      state_next;
   logic             in_ready_q;
   logic             in_fire;
   logic             out_fire;
   logic             main_load;
   logic [WIDTH-1:0] main_d;
   logic             skid_load;
   logic [WIDTH-1:0] skid_d;
   logic [WIDTH-1:0] skid_q;

   assign out_valid = (state != PS_EMPTY);
   assign count     = state_count(state);

   // With the skid buffer, ready comes straight from a flop; without it the
   // stage can only take a word when the head is leaving (or absent).
   assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // Next state and slot load decisions from the two handshakes.
   always_comb begin
      state_next = state;
      main_load  = 1'b0;
      main_d     = in_data;
      skid_load  = 1'b0;
      skid_d     = in_data;
      case (state)
         PS_EMPTY: begin
            if (in_fire) begin
               state_next = PS_ONE;
               main_load  = 1'b1;
            end
         end
         PS_ONE: begin
            if (in_fire && out_fire) begin
               main_load = 1'b1;
            end else if (in_fire && (SKID != 0)) begin
               state_next = PS_TWO;
               skid_load  = 1'b1;
            end else if (out_fire) begin
               state_next = PS_EMPTY;
               main_load  = 1'b1;
               main_d     = BUBBLE;
            end
         end
         PS_TWO: begin
            if (out_fire) begin
               state_next = PS_ONE;
               main_load  = 1'b1;
               main_d     = skid_q;
               skid_load  = 1'b1;
               skid_d     = BUBBLE;
            end
         end
         default: begin
            state_next = PS_EMPTY;
         end
      endcase
   end

   // Control FSM with registered in_ready; reset outranks flush, both empty the stage.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state      <= PS_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != PS_TWO);
      end
   end

   pipe_slot #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .load  (main_load),
      .d     (main_d),
      .q     (out_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
         ) u_skid (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .load  (skid_load),
            .d     (skid_d),
            .q     (skid_q)
         );
      end else begin : g_no_skid
         assign skid_q = BUBBLE;
      end
   endgenerate

endmodule
